// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_pkg
//  Description : Shared definitions for the LPDDR command-port arbiter:
//                MCB instruction codes, default widths, FSM state and
//                requester identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_pkg;

    // MCB command instruction encodings
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // Default command-port geometry
    localparam int DDR_ADDR_W = 30;
    localparam int DDR_BL_W   = 6;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Requester identity
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_e;

endpackage : ddr_pkg
`default_nettype wire

// File: rtl/ddr_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arb_pick
//  Description : Combinational winner selection for the command port:
//                urgent read > starved write > round-robin tie > single
//                eligible requester. Also computes write eligibility
//                (enough words already staged in the write-data FIFO).
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_arb_pick
    import ddr_pkg::*;
#(
    parameter int BL_W         = DDR_BL_W,
    parameter int WCNT_W       = 7,
    parameter int STARVE_LIMIT = 64,
    parameter int STARVE_W     = 7
) (
    input  logic                i_rd_req,
    input  logic                i_rd_urgent,
    input  logic                i_wr_req,
    input  logic [BL_W-1:0]     i_wr_bl,
    input  logic [WCNT_W-1:0]   i_wr_data_count,
    input  logic [STARVE_W-1:0] i_starve_cnt,
    input  req_id_e             i_last_winner,
    output logic                o_valid,
    output req_id_e             o_winner,
    output logic                o_wr_elig
);

    // Compare width wide enough that neither count nor bl+1 can wrap
    localparam int c_CMP_W = ((WCNT_W > BL_W) ? WCNT_W : BL_W) + 1;
    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [c_CMP_W-1:0] w_have;
    logic [c_CMP_W-1:0] w_need;
    logic               w_rd_elig;
    logic               w_wr_elig;
    logic               w_starved;

    assign w_have    = c_CMP_W'(i_wr_data_count);
    assign w_need    = c_CMP_W'(i_wr_bl) + c_CMP_W'(1);
    assign w_rd_elig = i_rd_req;
    assign w_wr_elig = i_wr_req && (w_have >= w_need);
    assign w_starved = w_wr_elig && (i_starve_cnt >= c_STARVE_MAX);
    assign o_wr_elig = w_wr_elig;

    // Fixed priority ladder; the tie case alternates against the last winner
    always_comb begin
        o_valid  = 1'b0;
        o_winner = REQ_RD;
        if (i_rd_urgent && w_rd_elig) begin
            o_valid  = 1'b1;
            o_winner = REQ_RD;
        end else if (w_starved) begin
            o_valid  = 1'b1;
            o_winner = REQ_WR;
        end else if (w_rd_elig && w_wr_elig) begin
            o_valid  = 1'b1;
            o_winner = (i_last_winner == REQ_WR) ? REQ_RD : REQ_WR;
        end else if (w_rd_elig) begin
            o_valid  = 1'b1;
            o_winner = REQ_RD;
        end else if (w_wr_elig) begin
            o_valid  = 1'b1;
            o_winner = REQ_WR;
        end
    end

endmodule : ddr_arb_pick
`default_nettype wire

// File: rtl/ddr_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_cmd_arbiter
//  Description : Shares one MCB command port between the display read path
//                and the frame write path. Picks a winner in IDLE, latches
//                the command, strobes it once the command FIFO has room,
//                then enforces a short idle gap before the next decision.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_cmd_arbiter
    import ddr_pkg::*;
#(
    parameter int ADDR_W       = DDR_ADDR_W,
    parameter int BL_W         = DDR_BL_W,
    parameter int WCNT_W       = 7,
    parameter int STARVE_LIMIT = 64,
    parameter int GAP          = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              rd_urgent,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BL_W-1:0]   rd_bl,
    output logic              rd_gnt,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BL_W-1:0]   wr_bl,
    input  logic [WCNT_W-1:0] wr_data_count,
    output logic              wr_gnt,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [BL_W-1:0]   cmd_bl,
    output logic [ADDR_W-1:0] cmd_byte_addr,
    input  logic              cmd_full,
    output logic              busy
);

    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [1:0] c_GAP_LAST  = (GAP > 0) ? 2'(GAP - 1) : 2'd0;
    localparam logic [ADDR_W-1:0] c_ADDR_MASK = ~ADDR_W'(3);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic                    w_latch;
    logic                    w_issue;
    logic [1:0]              r_gap_cnt;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    req_id_e                 r_last_winner;
    req_id_e                 r_owner;
    logic [2:0]              r_cmd_instr;
    logic [BL_W-1:0]         r_cmd_bl;
    logic [ADDR_W-1:0]       r_cmd_addr;
    logic                    w_pick_valid;
    req_id_e                 w_pick_id;
    logic                    w_wr_elig;

    ddr_arb_pick #(
        .BL_W         (BL_W),
        .WCNT_W       (WCNT_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .STARVE_W     (c_STARVE_W)
    ) u_pick (
        .i_rd_req        (rd_req),
        .i_rd_urgent     (rd_urgent),
        .i_wr_req        (wr_req),
        .i_wr_bl         (wr_bl),
        .i_wr_data_count (wr_data_count),
        .i_starve_cnt    (r_starve_cnt),
        .i_last_winner   (r_last_winner),
        .o_valid         (w_pick_valid),
        .o_winner        (w_pick_id),
        .o_wr_elig       (w_wr_elig)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic plus latch/issue strobes; reset suppresses any issue
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!cmd_full && !rst) begin
                    w_issue     = 1'b1;
                    w_state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gap cycle counter, restarts every time GAP is entered
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_GAP) r_gap_cnt <= 2'd0;
        else                          r_gap_cnt <= r_gap_cnt + 2'd1;
    end

    // Counts cycles an eligible write goes ungranted, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst)
            r_starve_cnt <= '0;
        else if (!w_wr_elig || (w_issue && r_owner == REQ_WR))
            r_starve_cnt <= '0;
        else if (r_starve_cnt < c_STARVE_MAX)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    // Command registers: loaded at the IDLE decision, held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_instr   <= 3'b000;
            r_cmd_bl      <= '0;
            r_cmd_addr    <= '0;
            r_owner       <= REQ_RD;
            r_last_winner <= REQ_WR;
        end else begin
            if (w_latch) begin
                r_owner <= w_pick_id;
                if (w_pick_id == REQ_WR) begin
                    r_cmd_instr <= CMD_WRITE;
                    r_cmd_bl    <= wr_bl;
                    r_cmd_addr  <= wr_addr & c_ADDR_MASK;
                end else begin
                    r_cmd_instr <= CMD_READ;
                    r_cmd_bl    <= rd_bl;
                    r_cmd_addr  <= rd_addr & c_ADDR_MASK;
                end
            end
            if (w_issue) r_last_winner <= r_owner;
        end
    end

    assign cmd_en        = w_issue;
    assign rd_gnt        = w_issue && (r_owner == REQ_RD);
    assign wr_gnt        = w_issue && (r_owner == REQ_WR);
    assign cmd_instr     = r_cmd_instr;
    assign cmd_bl        = r_cmd_bl;
    assign cmd_byte_addr = r_cmd_addr;
    assign busy          = (r_state != ST_IDLE);

endmodule : ddr_cmd_arbiter
`default_nettype wire

// File: tb/tb_ddr_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_cmd_arbiter
//  Description : Self-checking bench for ddr_cmd_arbiter. A timestamp-based
//                reference model (pending command, next decision cycle,
//                starvation count) predicts every output each cycle, with
//                directed scenarios followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_cmd_arbiter;

    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;
    localparam int WCNT_W = 7;
    localparam int LIMIT  = 64;
    localparam int GAPC   = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req, rd_urgent, wr_req, cmd_full;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [BL_W-1:0]   rd_bl, wr_bl;
    logic [WCNT_W-1:0] wr_data_count;
    logic              rd_gnt, wr_gnt, cmd_en, busy;
    logic [2:0]        cmd_instr;
    logic [BL_W-1:0]   cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;

    ddr_cmd_arbiter #(
        .ADDR_W(ADDR_W), .BL_W(BL_W), .WCNT_W(WCNT_W),
        .STARVE_LIMIT(LIMIT), .GAP(GAPC)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_bl(rd_bl),
        .rd_gnt(rd_gnt),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_bl(wr_bl),
        .wr_data_count(wr_data_count), .wr_gnt(wr_gnt),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a latched command waiting to go out, the cycle at
    // which the arbiter may next decide, and the write starvation count.
    bit                m_pending  = 1'b0;
    bit                m_own_wr   = 1'b0;
    bit                m_last_wr  = 1'b1;
    logic [2:0]        m_instr    = '0;
    logic [BL_W-1:0]   m_bl       = '0;
    logic [ADDR_W-1:0] m_addr     = '0;
    int                m_starve   = 0;
    int                m_decide_at = 0;
    int                cyc        = 0;

    bit rd_keep, wr_keep;
    bit q_gnt[$];   // observed grant order: 0 = read, 1 = write

    logic              obs_en, obs_rg, obs_wg, obs_busy;
    logic [2:0]        obs_instr;
    logic [BL_W-1:0]   obs_bl;
    logic [ADDR_W-1:0] obs_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then let the
    // requesters react to any grant just after the rising edge.
    task automatic step();
        bit exp_issue, issued_rd, issued_wr, wr_elig;
        int sel;
        @(negedge clk);
        obs_en = cmd_en; obs_rg = rd_gnt; obs_wg = wr_gnt; obs_busy = busy;
        obs_instr = cmd_instr; obs_bl = cmd_bl; obs_addr = cmd_byte_addr;
        if (obs_rg === 1'b1) q_gnt.push_back(1'b0);
        if (obs_wg === 1'b1) q_gnt.push_back(1'b1);

        exp_issue = !rst && m_pending && !cmd_full;
        issued_rd = exp_issue && !m_own_wr;
        issued_wr = exp_issue && m_own_wr;
        check("cmd_en", {63'd0, cmd_en}, {63'd0, exp_issue});
        check("rd_gnt", {63'd0, rd_gnt}, {63'd0, issued_rd});
        check("wr_gnt", {63'd0, wr_gnt}, {63'd0, issued_wr});
        if (!rst) begin
            check("busy", {63'd0, busy}, {63'd0, (m_pending || cyc < m_decide_at)});
            check("cmd_instr", 64'(cmd_instr), 64'(m_instr));
            check("cmd_bl", 64'(cmd_bl), 64'(m_bl));
            check("cmd_byte_addr", 64'(cmd_byte_addr), 64'(m_addr));
        end

        if (rst) begin
            m_pending = 0; m_own_wr = 0; m_last_wr = 1; m_starve = 0;
            m_decide_at = 0; m_instr = '0; m_bl = '0; m_addr = '0;
        end else begin
            wr_elig = wr_req && (int'(wr_data_count) >= int'(wr_bl) + 1);
            if (exp_issue) begin
                m_pending   = 0;
                m_last_wr   = m_own_wr;
                m_decide_at = cyc + 1 + GAPC;
            end else if (!m_pending && cyc >= m_decide_at) begin
                sel = 0;
                if (rd_urgent && rd_req)                  sel = 1;
                else if (wr_elig && m_starve >= LIMIT)    sel = 2;
                else if (rd_req && wr_elig)               sel = m_last_wr ? 1 : 2;
                else if (rd_req)                          sel = 1;
                else if (wr_elig)                         sel = 2;
                if (sel != 0) begin
                    m_pending = 1;
                    m_own_wr  = (sel == 2);
                    m_instr   = (sel == 2) ? 3'b000 : 3'b001;
                    m_bl      = (sel == 2) ? wr_bl : rd_bl;
                    m_addr    = ((sel == 2) ? wr_addr : rd_addr) & ~30'd3;
                end
            end
            if (!wr_elig || issued_wr) m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
        end
        cyc++;

        @(posedge clk);
        #1;
        if (issued_rd) begin
            if (rd_keep) rd_addr = rd_addr + 30'h40;
            else         rd_req  = 1'b0;
        end
        if (issued_wr) begin
            if (wr_keep) wr_addr = wr_addr + 30'h40;
            else         wr_req  = 1'b0;
        end
    endtask

    int n_wr;

    initial begin
        rst = 1'b1; rd_req = 0; rd_urgent = 0; wr_req = 0; cmd_full = 0;
        rd_addr = '0; wr_addr = '0; rd_bl = '0; wr_bl = '0; wr_data_count = '0;
        rd_keep = 0; wr_keep = 0;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        step();
        check("reset_busy", {63'd0, obs_busy}, 64'd0);
        check("reset_addr", 64'(obs_addr), 64'd0);

        // Single read: latch, then strobe on the following cycle
        rd_req = 1; rd_addr = 30'h1000; rd_bl = 6'd31;
        step();
        check("rd_only_latch_en", {63'd0, obs_en}, 64'd0);
        step();
        check("rd_only_en", {63'd0, obs_en}, 64'd1);
        check("rd_only_gnt", {63'd0, obs_rg}, 64'd1);
        check("rd_only_instr", 64'(obs_instr), 64'd1);
        check("rd_only_bl", 64'(obs_bl), 64'd31);
        check("rd_only_addr", 64'(obs_addr), 64'h1000);
        repeat (3) step();

        // Write held off until the data FIFO holds a full burst
        wr_req = 1; wr_bl = 6'd31; wr_data_count = 7'd31; wr_addr = 30'h2000;
        repeat (4) begin
            step();
            check("wr_gate_hold", {63'd0, obs_en}, 64'd0);
        end
        wr_data_count = 7'd32;
        step();
        check("wr_gate_latch", {63'd0, obs_en}, 64'd0);
        step();
        check("wr_gate_en", {63'd0, obs_en}, 64'd1);
        check("wr_gate_gnt", {63'd0, obs_wg}, 64'd1);
        check("wr_gate_instr", 64'(obs_instr), 64'd0);
        check("wr_gate_addr", 64'(obs_addr), 64'h2000);
        repeat (3) step();

        // Round-robin from reset: R, W, R, W
        rst = 1; step(); rst = 0;
        rd_keep = 1; wr_keep = 1; rd_req = 1; wr_req = 1; wr_data_count = 7'd127;
        q_gnt.delete();
        repeat (13) step();
        check("rr_grants", 64'(q_gnt.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_gnt.size(); i++)
            check("rr_order", {63'd0, q_gnt[i]}, {63'd0, i[0]});

        // Urgent reads hold off a write even once it is fully starved
        rd_urgent = 1; q_gnt.delete();
        repeat (90) step();
        n_wr = 0;
        foreach (q_gnt[i]) n_wr += int'(q_gnt[i]);
        check("urgent_no_write", 64'(n_wr), 64'd0);
        check("urgent_read_count", {63'd0, q_gnt.size() >= 25}, 64'd1);

        // Non-urgent read now loses to the starved write
        rd_urgent = 0; q_gnt.delete();
        repeat (9) step();
        check("starved_wr_wins", {63'd0, (q_gnt.size() >= 2) && (q_gnt[0] || q_gnt[1])}, 64'd1);

        // Drain both requesters
        rd_keep = 0; wr_keep = 0;
        repeat (10) step();

        // Backpressure: command held stable while the MCB FIFO is full
        cmd_full = 1; rd_req = 1; rd_addr = 30'h3ABF; rd_bl = 6'd7;
        step();
        step();
        check("bp_first_en", {63'd0, obs_en}, 64'd0);
        check("bp_addr_aligned", 64'(obs_addr), 64'h3ABC);
        repeat (5) begin
            step();
            check("bp_hold_en", {63'd0, obs_en}, 64'd0);
            check("bp_hold_busy", {63'd0, obs_busy}, 64'd1);
            check("bp_hold_addr", 64'(obs_addr), 64'h3ABC);
            check("bp_hold_bl", 64'(obs_bl), 64'd7);
        end
        cmd_full = 0; q_gnt.delete();
        step();
        check("bp_release_en", {63'd0, obs_en}, 64'd1);
        repeat (4) step();
        check("bp_single_gnt", 64'(q_gnt.size()), 64'd1);

        // Reset while stalled in ISSUE
        rd_req = 1; rd_addr = 30'h4000; cmd_full = 1;
        step(); step();
        rst = 1; rd_req = 0;
        step();
        check("rst_abort_en", {63'd0, obs_en}, 64'd0);
        rst = 0;
        step();
        check("rst_after_en", {63'd0, obs_en}, 64'd0);
        check("rst_after_busy", {63'd0, obs_busy}, 64'd0);
        check("rst_after_instr", 64'(obs_instr), 64'd0);
        check("rst_after_bl", 64'(obs_bl), 64'd0);
        check("rst_after_addr", 64'(obs_addr), 64'd0);
        cmd_full = 0; rd_req = 1; wr_req = 1; wr_data_count = 7'd127; q_gnt.delete();
        repeat (3) step();
        check("rst_tie_read", {63'd0, (q_gnt.size() >= 1) && (q_gnt[0] == 1'b0)}, 64'd1);

        // Randomized traffic, protocol-respecting requesters
        repeat (2500) begin
            if (!rd_req && $urandom_range(0, 2) != 0) begin
                rd_req = 1; rd_addr = ADDR_W'($urandom); rd_bl = BL_W'($urandom);
            end
            if (!wr_req && $urandom_range(0, 2) != 0) begin
                wr_req = 1; wr_addr = ADDR_W'($urandom); wr_bl = BL_W'($urandom);
            end
            rd_urgent = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) wr_data_count = WCNT_W'($urandom);
            cmd_full = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_ddr_cmd_arbiter
`default_nettype wire

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Shares the single LPDDR (MCB-style) command port between two requesters.
  - Display read path: the line buffer refill.
  - Frame write path: the capture or DMA writer.
- Arbitrates, sequences one command at a time, gates writes on write-data availability, and prevents starvation of either side.
- Sits between the requester controllers and the memory controller command FIFO.

Parameters:
- ADDR_W, 30, byte address width of command port
- BL_W, 6, burst length field width (value N encodes N+1 words)
- WCNT_W, 7, width of MCB write-data FIFO count
- STARVE_LIMIT, 64, cycles a pending eligible write may lose before it outranks non-urgent reads
- GAP, 1, idle cycles enforced after each issued command (0..3)

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- rd_req, in, 1, display read request (level, held until rd_gnt)
- rd_urgent, in, 1, display FIFO below low-water mark
- rd_addr, in, ADDR_W, read byte address
- rd_bl, in, BL_W, read burst length minus 1
- rd_gnt, out, 1, one-cycle pulse: read command issued
- wr_req, in, 1, write request (level, held until wr_gnt)
- wr_addr, in, ADDR_W, write byte address
- wr_bl, in, BL_W, write burst length minus 1
- wr_data_count, in, WCNT_W, words present in MCB write-data FIFO
- wr_gnt, out, 1, one-cycle pulse: write command issued
- cmd_en, out, 1, command strobe to MCB
- cmd_instr, out, 3, 3'b000 write, 3'b001 read
- cmd_bl, out, BL_W, burst length minus 1
- cmd_byte_addr, out, ADDR_W, command address, bits [1:0] forced to 0
- cmd_full, in, 1, MCB command FIFO full
- busy, out, 1, state not IDLE

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - starve_cnt 0.
  - last_winner = WRITE, so the first tie goes to read.
  - Reset asserted in any state aborts with no cmd_en that cycle.
- Eligibility:
  - rd_elig = rd_req.
  - wr_elig = wr_req && (wr_data_count >= wr_bl + 1), compared at WCNT_W+1 bits with no truncation.
- Priority when in IDLE, evaluated each cycle:
  - 1) rd_urgent && rd_elig -> READ.
  - 2) wr_elig && starve_cnt >= STARVE_LIMIT -> WRITE.
  - 3) both eligible -> the one not equal to last_winner (round-robin).
  - 4) single eligible -> that one.
- States:
  - IDLE:
    - If there is a winner, latch instr, bl, and addr into output registers and go to ISSUE.
    - Otherwise stay.
  - ISSUE:
    - If !cmd_full: cmd_en = 1 for exactly this cycle, the matching gnt pulses in the same cycle, last_winner is updated, then go to GAP state.
    - Otherwise hold and wait, with cmd_en 0 and outputs stable.
  - GAP:
    - Count GAP cycles, then return to IDLE.
    - GAP = 0 goes straight to IDLE the next cycle.
- Latency: from request eligible in IDLE to cmd_en is 2 cycles minimum (IDLE latch, ISSUE strobe).
- Latched commitment: the choice made in IDLE is committed. Requester changes after latching are ignored until gnt.
- Requester rules:
  - A requester deasserting req before gnt is a protocol error and has no effect on a latched command.
  - A requester must drop req, or present a new address, the cycle after gnt.
  - In GAP and IDLE the requester must not re-sample a stale req.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle wr_elig is true and a write is not granted.
  - Clears on wr_gnt or when wr_elig is false.
- cmd_instr, cmd_bl, and cmd_byte_addr are registered and hold their last values when cmd_en = 0.
- busy = (state != IDLE).

Decomposition:
- Shared package ddr_pkg holds:
  - CMD_WRITE = 3'b000 and CMD_READ = 3'b001.
  - ADDR_W and BL_W defaults.
  - State enum {IDLE, ISSUE, GAP}.
  - Requester id enum {REQ_RD, REQ_WR}.
- One natural sub-module: ddr_arb_pick (combinational priority/round-robin plus starvation compare), kept separate for unit testing.
- FSM and output registers live in the top.

Test Plan:
- Read only: rd_req=1, rd_addr=0x1000, rd_bl=31, cmd_full=0 -> cmd_en at cycle 2, cmd_instr=001, cmd_bl=31, cmd_byte_addr=0x1000, rd_gnt coincident.
- Write gating: wr_req=1, wr_bl=31, wr_data_count=31 -> no cmd_en. Raise count to 32 -> cmd_en with instr=000 two cycles later.
- Round-robin: rd and wr both continuously eligible, non-urgent -> grants alternate R,W,R,W starting with R after reset.
- Urgent and starvation:
  - rd_urgent held high with rd_req and wr eligible -> reads only until 64 wait cycles.
  - Then a non-urgent read loses to the write.
  - An urgent read still wins over the starved write.
- Backpressure: cmd_full=1 during ISSUE for 5 cycles -> cmd_en stays 0 and outputs are stable. cmd_full drops -> single cmd_en, single gnt.
- Reset mid-operation: rst asserted in ISSUE with cmd_full=1 -> next cycle all outputs 0, state IDLE, and the first subsequent tie goes to read.
